// File: rtl/lcd_pkg.sv
// Shared LCD geometry constants and the line-fetch state type.
// No logic, so no latency and no flow control.
package lcd_pkg;
  localparam int LCD_W     = 96;
  localparam int LCD_H     = 64;
  localparam int LCD_PAGES = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } lcd_fetch_state_t;
endpackage

// File: rtl/lcd_scanout_video_timing.sv
// h/v raster counters with registered sync/blank/de decode.
// Decode lags the counters by 1 clk; no backpressure, paced only by ce_pix.
module lcd_scanout_video_timing
  import lcd_pkg::*;
#(
  parameter int H_TOTAL  = 128,
  parameter int V_TOTAL  = 80,
  parameter int HS_START = 104,
  parameter int HS_LEN   = 8,
  parameter int VS_START = 68,
  parameter int VS_LEN   = 2,
  parameter int HW       = $clog2(H_TOTAL),
  parameter int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          wrap,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de
);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(LCD_W);
  localparam logic [VW-1:0] V_ACT  = VW'(LCD_H);
  localparam logic [HW-1:0] HS_B   = HW'(HS_START);
  localparam logic [HW-1:0] HS_E   = HW'(HS_START + HS_LEN);
  localparam logic [VW-1:0] VS_B   = VW'(VS_START);
  localparam logic [VW-1:0] VS_E   = VW'(VS_START + VS_LEN);

  assign wrap = ce_pix && (h == H_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (ce_pix) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      hblank <= 1'b0;
      vblank <= 1'b0;
      de     <= 1'b0;
    end else begin
      hsync  <= (h >= HS_B) && (h < HS_E);
      vsync  <= (v >= VS_B) && (v < VS_E);
      hblank <= (h >= H_ACT);
      vblank <= (v >= V_ACT);
      de     <= (h < H_ACT) && (v < V_ACT);
    end
  end
endmodule

// File: rtl/lcd_scanout.sv
// LCD RAM scanout: prefetches each line in the previous hblank, emits 8-bit grey.
// Pixel/sync 1 clk after ce_pix; no backpressure, RAM answers 1 clk after address.
module lcd_scanout
  import lcd_pkg::*;
#(
  parameter int         H_TOTAL   = 128,
  parameter int         V_TOTAL   = 80,
  parameter int         HS_START  = 104,
  parameter int         HS_LEN    = 8,
  parameter int         VS_START  = 68,
  parameter int         VS_LEN    = 2,
  parameter logic [7:0] OFF_LEVEL = 8'hE0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [5:0] lcd_contrast,
  output logic [7:0] lcd_read_x,
  output logic [3:0] lcd_read_y,
  input  logic [7:0] lcd_read_column,
  output logic [7:0] pixel,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       de
);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_ACT    = HW'(LCD_W);
  localparam logic [VW-1:0] V_ACT    = VW'(LCD_H);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [6:0]    COL_LAST = 7'(LCD_W - 1);

  logic [HW-1:0]       h;
  logic [VW-1:0]       v;
  logic                wrap;
  lcd_fetch_state_t    state, state_nx;
  logic [6:0]          col;
  logic [5:0]          tline;
  logic [VW-1:0]       t_next;
  logic                start;
  logic                store;
  logic [6:0]          store_idx;
  logic [$clog2(LCD_PAGES)-1:0] page;
  logic [LCD_W-1:0]    front, back;
  logic [6:0]          hx;
  logic                active;
  logic [8:0]          lit_wide;
  logic [7:0]          pixel_nx;

  lcd_scanout_video_timing #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .HS_START(HS_START), .HS_LEN(HS_LEN),
    .VS_START(VS_START), .VS_LEN(VS_LEN), .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .h(h), .v(v), .wrap(wrap),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de)
  );

  // The line after the last one of the frame is line 0; lines past the panel are never fetched.
  assign t_next = (v == V_LAST) ? '0 : v + 1'b1;
  assign start  = ce_pix && (h == H_ACT) && (t_next < V_ACT);
  assign page   = tline[5:3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   if (col == COL_LAST) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Data for column col-1 arrives while column col is being addressed.
  always_comb begin
    lcd_read_x = '0;
    lcd_read_y = '0;
    store      = 1'b0;
    store_idx  = '0;
    case (state)
      FETCH: begin
        lcd_read_x = {1'b0, col};
        lcd_read_y = {1'b0, page};
        store      = (col != 7'd0);
        store_idx  = col - 7'd1;
      end
      DRAIN: begin
        store     = 1'b1;
        store_idx = COL_LAST;
      end
      default: ;
    endcase
  end

  assign hx       = h[6:0];
  assign active   = (h < H_ACT) && (v < V_ACT);
  assign lit_wide = {1'b0, OFF_LEVEL} - {1'b0, lcd_contrast, 2'b00};

  always_comb begin
    pixel_nx = '0;
    if (active) pixel_nx = front[hx] ? (lit_wide[8] ? 8'h00 : lit_wide[7:0]) : OFF_LEVEL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col   <= '0;
      tline <= '0;
      front <= '0;
      back  <= '0;
      pixel <= '0;
    end else begin
      if (state == IDLE && start) begin
        col   <= '0;
        tline <= t_next[5:0];
      end else if (state == FETCH) begin
        col <= col + 7'd1;
      end
      if (store) back[store_idx] <= lcd_read_column[tline[2:0]];
      if (wrap)  front <= back;
      pixel <= pixel_nx;
    end
  end
endmodule

// File: tb/tb_lcd_scanout.sv
// Randomized scanout bench with a pixel/timing reference model built from raster rules.
module tb_lcd_scanout;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce_pix = 1'b0;
  logic [5:0] lcd_contrast = 6'd0;
  logic [7:0] lcd_read_x;
  logic [3:0] lcd_read_y;
  logic [7:0] lcd_read_column;
  logic [7:0] pixel;
  logic       hsync, vsync, hblank, vblank, de;

  lcd_scanout dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .lcd_contrast(lcd_contrast),
    .lcd_read_x(lcd_read_x), .lcd_read_y(lcd_read_y), .lcd_read_column(lcd_read_column),
    .pixel(pixel), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de)
  );

  always #5 clk = ~clk;

  // Display RAM: [page][column], registered read.
  logic [7:0] mem [8][96];
  always @(posedge clk) begin : ram
    int ix, iy;
    ix = int'(lcd_read_x);
    iy = int'(lcd_read_y[2:0]);
    lcd_read_column <= (ix < 96) ? mem[iy][ix] : 8'h00;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int hm, vm, ph, tickno, fstart, ft, xprev;
  bit [95:0] mfront, mback;
  int n_de, n_hs, n_hs_rise, n_vs, n_vs_rise, n_fetch;
  bit hs_prev, vs_prev;
  bit dir_frame1 = 0;
  bit line0_off = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lit_level(input int c);
    int l;
    l = 224 - 4 * c;
    return (l < 0) ? 0 : l;
  endfunction

  task automatic fill_mem(input logic [7:0] b);
    for (int p = 0; p < 8; p++)
      for (int x = 0; x < 96; x++) mem[p][x] = b;
  endtask

  task automatic clear_stats();
    n_de = 0; n_hs = 0; n_hs_rise = 0; n_vs = 0; n_vs_rise = 0; n_fetch = 0;
  endtask

  task automatic apply_reset();
    ce_pix = 1'b0;
    reset  = 1'b1;
    #1;
    chk("rst_pixel", pixel, 0);
    chk("rst_sync", {hsync, vsync, hblank, vblank, de}, 0);
    chk("rst_read_x", lcd_read_x, 0);
    chk("rst_read_y", lcd_read_y, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_pixel", pixel, 0);
    chk("rst_hold_x", lcd_read_x, 0);
    hm = 0; vm = 0; ph = 0; xprev = 0;
    mfront = '0; mback = '0;
    hs_prev = 0; vs_prev = 0;
    reset = 1'b0;
  endtask

  // One clk: drive ce_pix, let the edge happen, predict registered outputs, compare.
  task automatic tick();
    bit ce, act;
    int eh, ev, c, ep, t;
    ce = (ph % 4) == 3;
    ce_pix = ce;
    @(posedge clk);
    eh = hm; ev = vm; c = int'(lcd_contrast);
    act = (eh < 96) && (ev < 64);
    ep = 0;
    if (act) ep = mfront[eh] ? lit_level(c) : 224;
    if (ce) begin
      if (hm == 96) begin
        t = (vm + 1 == 80) ? 0 : vm + 1;
        if (t < 64) begin
          for (int x = 0; x < 96; x++) mback[x] = mem[t / 8][x][t % 8];
          ft = t;
          fstart = tickno;
        end
      end
      if (hm == 127) begin
        mfront = mback;
        hm = 0;
        vm = (vm == 79) ? 0 : vm + 1;
      end else begin
        hm++;
      end
    end
    #1;
    chk("pixel", pixel, ep);
    chk("hsync", hsync, (eh >= 104 && eh < 112));
    chk("vsync", vsync, (ev >= 68 && ev < 70));
    chk("hblank", hblank, (eh >= 96));
    chk("vblank", vblank, (ev >= 64));
    chk("de", de, act);
    if (dir_frame1 && act) begin
      if (eh == 0 && ev == 0)        chk("px_0_0", pixel, 8'hC0);
      else if (eh == 95 && ev == 63) chk("px_95_63", pixel, 8'h00);
      else                           chk("px_unlit", pixel, 8'hE0);
    end
    if (line0_off && act) chk("line0_after_reset", pixel, 8'hE0);
    if (lcd_read_x != 8'd0) chk("addr_seq", lcd_read_x, xprev + 1);
    if (lcd_read_x == 8'd95) begin
      n_fetch++;
      chk("fetch_len", tickno - fstart, 95);
      chk("read_y", lcd_read_y, ft / 8);
      chk("fetch_in_hblank", (hm > 96), 1);
    end
    xprev = int'(lcd_read_x);
    if (de) n_de++;
    if (hsync) n_hs++;
    if (vsync) n_vs++;
    if (hsync && !hs_prev) n_hs_rise++;
    if (vsync && !vs_prev) n_vs_rise++;
    hs_prev = hsync;
    vs_prev = vsync;
    ph++;
    tickno++;
  endtask

  initial begin
    bit hit;
    tickno = 0; fstart = -1000; ft = 0;
    fill_mem(8'h00);
    #2;
    apply_reset();

    // Frame 0: random image, random contrast changes.
    for (int p = 0; p < 8; p++)
      for (int x = 0; x < 96; x++) mem[p][x] = 8'($urandom_range(0, 255));
    clear_stats();
    for (int i = 0; i < 70 * 512; i++) begin
      if ($urandom_range(0, 63) == 0) lcd_contrast = 6'($urandom_range(0, 63));
      tick();
    end
    fill_mem(8'h00);
    mem[0][0]  = 8'h01;
    mem[7][95] = 8'h80;
    for (int i = 0; i < 10 * 512; i++) begin
      if ($urandom_range(0, 63) == 0) lcd_contrast = 6'($urandom_range(0, 63));
      tick();
    end
    chk("frame_de_clks", n_de, 96 * 64 * 4);
    chk("frame_hs_clks", n_hs, 80 * 8 * 4);
    chk("frame_hs_pulses", n_hs_rise, 80);
    chk("frame_vs_clks", n_vs, 2 * 128 * 4);
    chk("frame_vs_pulses", n_vs_rise, 1);
    chk("frame_fetches", n_fetch, 64);

    // Frame 1: two single lit pixels at the image corners.
    dir_frame1 = 1;
    lcd_contrast = 6'd8;
    for (int i = 0; i < 32 * 512; i++) tick();
    lcd_contrast = 6'd63;
    for (int i = 0; i < 32 * 512; i++) tick();
    dir_frame1 = 0;

    // Reset in the middle of a fetch, then contrast step on a fully lit line.
    apply_reset();
    fill_mem(8'hFF);
    lcd_contrast = 6'd16;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      tick();
      hit = (lcd_read_x == 8'd40);
    end
    chk("reach_col40", hit, 1);
    apply_reset();
    line0_off = 1;
    for (int i = 0; i < 512; i++) tick();
    line0_off = 0;
    lcd_contrast = 6'd0;
    for (int i = 0; i < 192; i++) tick();
    chk("contrast_pre_step", pixel, 8'hE0);
    lcd_contrast = 6'd16;
    tick();
    chk("contrast_post_step", pixel, 8'hA0);
    for (int i = 0; i < 512 - 193; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
